muldiv_seq: RTL

Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle ALU does not implement. It sits beside the ALU in the execute stage. When the decoder flags an M-extension R-type instruction (opcode 0110011, funct7 = 0000001), the control unit pulses a start. The block then holds the pipeline via `busy_o`, runs an iterative 32-step shift-add multiply or restoring divide, and returns one 32-bit result with a single-cycle `done_o`.

---
 rtl/rv_pkg.sv | 41 ++++
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32M multiply/divide definitions: op codes, sequencer states and
// helpers that classify an op by kind and operand signedness.
package rv_pkg;

  localparam int          XLEN          = 32;
  localparam int          MULDIV_ITER   = 32;
  localparam int          MULDIV_CNT_W  = $clog2(MULDIV_ITER);
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute-stage control and the
// multi-cycle M-extension sequencer.
interface muldiv_seq_if;

  logic                     start_i;
  logic [2:0]               funct3_i;
  logic [rv_pkg::XLEN-1:0]  op_a_i;
  logic [rv_pkg::XLEN-1:0]  op_b_i;
  logic                     kill_i;
  logic                     busy_o;
  logic                     done_o;
  logic [rv_pkg::XLEN-1:0]  result_o;

  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, kill_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, kill_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: shift-add multiply on a 64-bit
// product, or restoring-divide step on {rem, quo}. Purely combinational.
module muldiv_step
  import rv_pkg::*;
(
  input  logic            i_is_div,
  input  logic [63:0]     i_acc,
  input  logic [XLEN-1:0] i_opnd,
  output logic [63:0]     o_acc
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    w_sum   = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    // Shifted partial remainder is 33 bits wide; it never exceeds 2*divisor.
    w_shift = i_acc[63:31];
    w_ge    = (w_shift >= {1'b0, i_opnd});
    w_diff  = w_shift[XLEN-1:0] - i_opnd;
    o_acc   = {w_sum, i_acc[31:1]};
    if (i_is_div) begin
      if (w_ge) o_acc = {w_diff,             i_acc[30:0], 1'b1};
      else      o_acc = {w_shift[XLEN-1:0],  i_acc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: captures operand magnitudes, iterates 32 steps
// of muldiv_step, applies the sign fix-up and returns one result with done_o.
module muldiv_seq
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);

  muldiv_state_e           r_state, w_state_nxt;
  muldiv_op_e              r_op, w_op;
  logic                    r_sign_a, r_sign_b;
  logic [63:0]             r_acc, w_step_acc;
  logic [XLEN-1:0]         r_opnd, r_result;
  logic [MULDIV_CNT_W-1:0] r_cnt;

  logic                    w_is_div, w_run_div, w_fast;
  logic                    w_sign_a, w_sign_b;
  logic [XLEN-1:0]         w_mag_a, w_mag_b, w_fast_result;
  logic [63:0]             w_prod;
  logic [XLEN-1:0]         w_quo, w_rem, w_fix_result;
  logic                    w_busy, w_done;

  // Operand capture decode and the two division short-cuts.
  always_comb begin
    w_op          = muldiv_op_e'(bus.funct3_i);
    w_is_div      = op_is_div(w_op);
    w_sign_a      = op_signed_a(w_op) & bus.op_a_i[XLEN-1];
    w_sign_b      = op_signed_b(w_op) & bus.op_b_i[XLEN-1];
    w_mag_a       = w_sign_a ? -bus.op_a_i : bus.op_a_i;
    w_mag_b       = w_sign_b ? -bus.op_b_i : bus.op_b_i;
    w_fast        = 1'b0;
    w_fast_result = '0;
    if (w_is_div) begin
      if (bus.op_b_i == '0) begin
        w_fast        = 1'b1;
        w_fast_result = (w_op inside {OP_DIV, OP_DIVU}) ? '1 : bus.op_a_i;
      end else if ((w_op inside {OP_DIV, OP_REM}) &&
                   (bus.op_a_i == INT_MIN) && (bus.op_b_i == '1)) begin
        w_fast        = 1'b1;
        w_fast_result = (w_op == OP_DIV) ? INT_MIN : '0;
      end
    end
  end

  assign w_run_div = op_is_div(r_op);

  muldiv_step u_step (
    .i_is_div (w_run_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc)
  );

  // Sign fix-up applied to the finished magnitude result.
  always_comb begin
    w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    w_quo  = (r_sign_a ^ r_sign_b) ? -r_acc[31:0] : r_acc[31:0];
    w_rem  = r_sign_a ? -r_acc[63:32] : r_acc[63:32];
    case (r_op)
      OP_MUL:                       w_fix_result = w_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[63:32];
      OP_DIV, OP_DIVU:              w_fix_result = w_quo;
      default:                      w_fix_result = w_rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.kill_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start_i) w_state_nxt = w_fast ? ST_DONE : ST_CALC;
        ST_CALC: if (r_cnt == '0) w_state_nxt = ST_FIX;
        ST_FIX:  w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    w_busy = (r_state == ST_CALC) || (r_state == ST_FIX);
    w_done = (r_state == ST_DONE);
  end

  // NOTE: every datapath register has an explicit reset value; there is no
  // memory array here, so nothing is left to power up as X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i && !bus.kill_i) begin
            r_op     <= w_op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_acc    <= {32'b0, (w_is_div ? w_mag_a : w_mag_b)};
            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
            r_cnt    <= w_fast ? '0 : MULDIV_CNT_W'(MULDIV_ITER - 1);
            if (w_fast) r_result <= w_fast_result;
          end
        end
        ST_CALC: begin
          if (bus.kill_i) begin
            r_cnt <= '0;
          end else begin
            r_acc <= w_step_acc;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          if (!bus.kill_i) r_result <= w_fix_result;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = w_busy;
  assign bus.done_o   = w_done;
  assign bus.result_o = r_result;

endmodule
